trig_sched: RTL

Upstream trigger scheduler for the 4-state dummy state machine (`dummy_sm`, states IDLE=0, RUN=1, WAIT=2, DONE=3).
- Converts rising edges on a level request line into queued start requests.
- Issues each request as a single-cycle `trigger` pulse, only when the downstream machine reports IDLE.
- Enforces a minimum holdoff after each downstream run completes, and flags lost requests and unacknowledged triggers.

---
 rtl/trig_sched.sv | 96 +++++++++
 1 files changed

// File: rtl/trig_sched.sv
// trig_sched: turns rising edges on a level request into queued start pulses
// for a downstream 4-state machine, issuing one pulse per request only while
// the downstream reports IDLE. Enforces a holdoff after each run and flags
// dropped requests and unacknowledged triggers.
module trig_sched #(
  parameter int HOLDOFF  = 4,
  parameter int ACK_TO   = 8,
  parameter int MAX_PEND = 7,
  parameter int PEND_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic [1:0]        sm_state,
  output logic              trigger,
  output logic [PEND_W-1:0] pending,
  output logic              busy,
  output logic              overflow,
  output logic              ack_err
);

  // One timer serves both the ack timeout and the holdoff.
  localparam int TMAX = (ACK_TO > HOLDOFF) ? ACK_TO : HOLDOFF;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [PEND_W-1:0] PMAX = PEND_W'(MAX_PEND);

  typedef enum logic [2:0] {S_IDLE, S_FIRE, S_ACK, S_RUN, S_HOLD} state_t;

  state_t          state, nxt;
  logic            req_d;
  logic [TW-1:0]   timer;
  logic            rise, issue, sm_idle;
  logic            ack_hit, hold_done, ack_fail;

  assign rise    = req_in & ~req_d;
  assign issue   = (state == S_FIRE);
  assign sm_idle = (sm_state == 2'd0);

  // "Reaches the limit" on this edge: timer+1 is the value it would take.
  // Written as >= so HOLDOFF = 0 exits S_HOLD immediately (ack-timeout path).
  assign ack_hit   = (32'(timer) + 32'd1) >= 32'(ACK_TO);
  assign hold_done = (32'(timer) + 32'd1) >= 32'(HOLDOFF);

  // Next-state decode; outputs are registered from nxt so they line up with state.
  always_comb begin
    nxt      = state;
    ack_fail = 1'b0;
    case (state)
      S_IDLE: if (pending != '0 && sm_idle) nxt = S_FIRE;
      S_FIRE: nxt = S_ACK;
      S_ACK: begin
        if (!sm_idle) nxt = S_RUN;
        else if (ack_hit) begin
          nxt      = S_HOLD;
          ack_fail = 1'b1;
        end
      end
      S_RUN:  if (sm_idle) nxt = (HOLDOFF > 0) ? S_HOLD : S_IDLE;
      S_HOLD: if (hold_done) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // State, timer, pending counter and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      req_d    <= 1'b0;
      timer    <= '0;
      pending  <= '0;
      trigger  <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      state   <= nxt;
      req_d   <= req_in;
      trigger <= (nxt == S_FIRE);
      busy    <= (nxt != S_IDLE);

      if (nxt != state)                        timer <= '0;
      else if (state == S_ACK || state == S_HOLD) timer <= timer + 1'b1;

      if (ack_fail) ack_err <= 1'b1;

      // A rise coinciding with an issue nets to zero, even at full capacity.
      if (rise && !issue) begin
        if (pending == PMAX) overflow <= 1'b1;
        else                 pending  <= pending + 1'b1;
      end else if (!rise && issue) begin
        pending <= pending - 1'b1;
      end
    end
  end

endmodule
